// File: rtl/wdt_pkg.sv
// Shared watchdog definitions: state encoding and default widths.
`timescale 1ns/1ps
package wdt_pkg;

  localparam int TMO_W_DEF        = 16;
  localparam int EXP_W_DEF        = 8;
  localparam int RST_PULSE_MS_DEF = 10;

  // Encoding is visible on wdt_state, so values are fixed.
  typedef enum logic [1:0] {
    WDT_IDLE = 2'd0,
    WDT_RUN  = 2'd1,
    WDT_WARN = 2'd2,
    WDT_FIRE = 2'd3
  } wdt_state_e;

endpackage

// File: rtl/wdt_fire_pulse.sv
// Counts ms_pulse strobes while the watchdog is firing and flags the last one.
`timescale 1ns/1ps
module wdt_fire_pulse #(
  parameter int RST_PULSE_MS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,    // FIRE entry: restart the stretch count
  input  logic active_i,   // FIRE is the current state
  input  logic ms_pulse_i,
  output logic done_o      // last ms of the stretch; FIRE exits on this edge
);

  localparam int PW = (RST_PULSE_MS > 1) ? $clog2(RST_PULSE_MS) : 1;
  localparam logic [PW-1:0] LAST = PW'(RST_PULSE_MS - 1);

  logic [PW-1:0] pulse_cnt_q;
  logic [PW-1:0] pulse_cnt_d;

  assign done_o = active_i && ms_pulse_i && (pulse_cnt_q == LAST);

  // Next stretch count: load on entry, advance on each ms while active.
  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    if (start_i) begin
      pulse_cnt_d = '0;
    end else if (active_i && ms_pulse_i) begin
      pulse_cnt_d = done_o ? '0 : pulse_cnt_q + PW'(1);
    end
  end

  // Stretch counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulse_cnt_q <= '0;
    else        pulse_cnt_q <= pulse_cnt_d;
  end

endmodule

// File: rtl/ms_watchdog.sv
// Millisecond watchdog: counts ms strobes since the last kick, warns, then
// requests a reset for a fixed number of milliseconds.
`timescale 1ns/1ps
module ms_watchdog
  import wdt_pkg::*;
#(
  parameter int TMO_W        = TMO_W_DEF,
  parameter int RST_PULSE_MS = RST_PULSE_MS_DEF,
  parameter int EXP_W        = EXP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ms_pulse,
  input  logic             wdt_en,
  input  logic             kick,
  input  logic [TMO_W-1:0] timeout_ms,
  input  logic [TMO_W-1:0] warn_ms,
  output logic [1:0]       wdt_state,
  output logic             wdt_warn,
  output logic             wdt_rst_req,
  output logic [EXP_W-1:0] expire_cnt
);

  wdt_state_e       state_q, state_d;
  logic [TMO_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [EXP_W-1:0] expire_q, expire_d;
  logic             warn_q, rst_req_q;
  logic [TMO_W-1:0] eff_timeout;
  logic             warn_en;
  logic             fire_start;
  logic             fire_done;

  // A zero timeout would fire immediately out of reset; treat it as 1 ms.
  assign eff_timeout = (timeout_ms == '0) ? TMO_W'(1) : timeout_ms;
  assign warn_en     = (warn_ms != '0) && (warn_ms < timeout_ms);
  assign fire_start  = (state_d == WDT_FIRE) && (state_q != WDT_FIRE);

  wdt_fire_pulse #(.RST_PULSE_MS(RST_PULSE_MS)) u_fire (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (fire_start),
    .active_i   (state_q == WDT_FIRE),
    .ms_pulse_i (ms_pulse),
    .done_o     (fire_done)
  );

  // Next state and ms counter; thresholds compare the registered count.
  always_comb begin
    state_d  = state_q;
    ms_cnt_d = ms_cnt_q;
    unique case (state_q)
      WDT_IDLE: begin
        ms_cnt_d = '0;
        if (wdt_en) state_d = WDT_RUN;
      end
      WDT_RUN, WDT_WARN: begin
        if (kick)                            ms_cnt_d = '0;
        else if (ms_pulse && ms_cnt_q != '1) ms_cnt_d = ms_cnt_q + TMO_W'(1);
        if (!wdt_en) begin
          state_d  = WDT_IDLE;
          ms_cnt_d = '0;
        end else if (ms_cnt_q >= eff_timeout) begin
          // Deadline already reached: a late kick cannot rescue it.
          state_d  = WDT_FIRE;
          ms_cnt_d = '0;
        end else if (state_q == WDT_WARN) begin
          if (kick) state_d = WDT_RUN;
        end else if (warn_en && !kick && ms_cnt_q >= warn_ms) begin
          state_d = WDT_WARN;
        end
      end
      WDT_FIRE: begin
        // Kick and enable are ignored until the full stretch completes.
        ms_cnt_d = '0;
        if (fire_done) state_d = wdt_en ? WDT_RUN : WDT_IDLE;
      end
      default: state_d = WDT_IDLE;
    endcase
  end

  // Saturating count of FIRE entries.
  always_comb begin
    expire_d = expire_q;
    if (fire_start && expire_q != '1) expire_d = expire_q + EXP_W'(1);
  end

  // State, counter and output flops all update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WDT_IDLE;
      ms_cnt_q  <= '0;
      expire_q  <= '0;
      warn_q    <= 1'b0;
      rst_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ms_cnt_q  <= ms_cnt_d;
      expire_q  <= expire_d;
      warn_q    <= (state_d == WDT_WARN);
      rst_req_q <= (state_d == WDT_FIRE);
    end
  end

  assign wdt_state   = state_q;
  assign wdt_warn    = warn_q;
  assign wdt_rst_req = rst_req_q;
  assign expire_cnt  = expire_q;

endmodule
